// File: rtl/redundant_multiplier_array.sv
// Redundant single-precision multiply stage: launches one multiply on NUM_UNITS
// staggered cores, collects results under a timeout, streams them and flags disagreement.

module verilog_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] res,
  output logic        done
);

  // Round-to-nearest-even increment decision.
  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  // Exponent saturation to infinity/zero; subnormal results flush to signed zero.
  function automatic logic [31:0] pack_sat(input logic sgn, input logic signed [9:0] exp,
                                           input logic [22:0] mant);
    if (exp >= 10'sd255)
      return {sgn, 8'hFF, 23'd0};
    else if (exp <= 10'sd0)
      return {sgn, 31'd0};
    else
      return {sgn, exp[7:0], mant};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]        prod;
    logic [22:0]        mant;
    logic               guard, sticky;
    logic [23:0]        mrnd;
    logic signed [9:0]  exp;
    sgn    = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      return 32'h7FC00000;
    if (a_inf || b_inf)
      return {sgn, 8'hFF, 23'd0};
    if (a_zero || b_zero)
      return {sgn, 31'd0};
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp    = exp + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    mrnd = {1'b0, mant} + {23'd0, rne_up(mant[0], guard, sticky)};
    if (mrnd[23])
      exp = exp + 10'sd1;
    return pack_sat(sgn, exp, mrnd[22:0]);
  endfunction

  // ---- stage p0: result registered one cycle after the ready pulse ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res  <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= ready;
      if (ready)
        res <= fp_mul(op1, op2);
    end
  end

endmodule

module redundant_multiplier_array #(
  parameter int NUM_UNITS = 2,
  parameter int STAGGER   = 1,
  parameter int TIMEOUT   = 255,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [31:0]      op1,
  input  logic [31:0]      op2,
  output logic [31:0]      res,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_valid,
  output logic             done,
  output logic             mismatch,
  output logic             timeout,
  output logic             busy
);

  localparam int          LAST_LAUNCH = (NUM_UNITS - 1) * STAGGER;
  localparam logic [31:0] QNAN        = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, STREAM, FINISH} state_t;

  state_t                       state, state_nxt;
  logic [31:0]                  op1_p0, op2_p0;
  logic [7:0]                   lcnt;
  logic [31:0]                  tcnt;
  logic [IDX_W-1:0]             scnt;
  logic [NUM_UNITS-1:0]         seen, seen_nxt;
  logic [NUM_UNITS-1:0][31:0]   buf_r, buf_nxt;
  logic [NUM_UNITS-1:0]         unit_ready, unit_done;
  logic [NUM_UNITS-1:0][31:0]   unit_res;
  logic                         all_seen, wait_exp, mm;
  logic [IDX_W-1:0]             sel_idx;
  logic [NUM_UNITS-1:0]         sel_seen;
  logic [NUM_UNITS-1:0][31:0]   sel_buf;
  logic [31:0]                  sel_word;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
    logic        u_done;
    logic [31:0] u_res;
    verilog_multiplier u_mul (
      .clk   (clk),
      .rst   (rst),
      .ready (unit_ready[k]),
      .op1   (op1_p0),
      .op2   (op2_p0),
      .res   (u_res),
      .done  (u_done)
    );
    assign unit_ready[k] = (state == LAUNCH) && (lcnt == 8'(k * STAGGER));
    assign unit_done[k]  = u_done;
    assign unit_res[k]   = u_res;
  end

  // First completion per unit wins; later done pulses are ignored.
  always_comb begin
    seen_nxt = seen;
    buf_nxt  = buf_r;
    if (state == LAUNCH || state == WAIT) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (unit_done[k] && !seen[k]) begin
          seen_nxt[k] = 1'b1;
          buf_nxt[k]  = unit_res[k];
        end
      end
    end
  end

  assign all_seen = &seen_nxt;
  assign wait_exp = (TIMEOUT != 0) && (tcnt == 32'(TIMEOUT - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    mm = 1'b0;
    for (int k = 1; k < NUM_UNITS; k++)
      if (seen[k] && seen[0] && (buf_r[k] != buf_r[0]))
        mm = 1'b1;
  end

  // Word for the next beat; the first beat must see captures landing this cycle.
  always_comb begin
    sel_idx  = '0;
    sel_seen = seen;
    sel_buf  = buf_r;
    if (state == WAIT) begin
      sel_seen = seen_nxt;
      sel_buf  = buf_nxt;
    end else begin
      sel_idx = scnt + IDX_W'(1);
    end
    sel_word = QNAN;
    for (int k = 0; k < NUM_UNITS; k++)
      if ((IDX_W'(k) == sel_idx) && sel_seen[k])
        sel_word = sel_buf[k];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ready) state_nxt = LAUNCH;
      LAUNCH:  if (lcnt == 8'(LAST_LAUNCH)) state_nxt = WAIT;
      WAIT:    if (all_seen || wait_exp) state_nxt = STREAM;
      STREAM:  if (scnt == IDX_W'(NUM_UNITS - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: control, capture buffers and output stream registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op1_p0    <= 32'd0;
      op2_p0    <= 32'd0;
      lcnt      <= 8'd0;
      tcnt      <= 32'd0;
      scnt      <= '0;
      seen      <= '0;
      buf_r     <= '0;
      res       <= 32'd0;
      res_idx   <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      seen  <= seen_nxt;
      buf_r <= buf_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            op1_p0   <= op1;
            op2_p0   <= op2;
            seen     <= '0;
            mismatch <= 1'b0;
            timeout  <= 1'b0;
            lcnt     <= 8'd0;
          end
        end
        LAUNCH: begin
          lcnt <= lcnt + 8'd1;
          tcnt <= 32'd0;
        end
        WAIT: begin
          tcnt <= tcnt + 32'd1;
          if (state_nxt == STREAM) begin
            res       <= sel_word;
            res_idx   <= '0;
            res_valid <= 1'b1;
            scnt      <= '0;
            if (!all_seen)
              timeout <= 1'b1;
          end
        end
        STREAM: begin
          if (scnt == IDX_W'(NUM_UNITS - 1)) begin
            res_valid <= 1'b0;
            done      <= 1'b1;
            mismatch  <= mm;
          end else begin
            scnt    <= scnt + IDX_W'(1);
            res_idx <= scnt + IDX_W'(1);
            res     <= sel_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_redundant_multiplier_array.sv
// Scoreboard bench for redundant_multiplier_array: random and directed multiplies,
// forced unit faults (mismatch/timeout), reset abort and back-to-back requests.

module tb_redundant_multiplier_array;

  localparam int N  = 3;
  localparam int S  = 2;
  localparam int TO = 20;
  localparam int IW = 2;
  localparam int MIN_LAT = (N - 1) * S + 1 + 1 + N;   // accept edge to done cycle
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready = 1'b0;
  logic [31:0]   op1 = 32'd0, op2 = 32'd0;
  logic [31:0]   res;
  logic [IW-1:0] res_idx;
  logic          res_valid, done, mismatch, timeout, busy;

  redundant_multiplier_array #(.NUM_UNITS(N), .STAGGER(S), .TIMEOUT(TO), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .ready(ready), .op1(op1), .op2(op2),
    .res(res), .res_idx(res_idx), .res_valid(res_valid), .done(done),
    .mismatch(mismatch), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [1:0]  idx;
    logic [31:0] data;
    bit          mm;
    bit          to;
  } exp_t;

  exp_t sbq[$];
  int   nchecks = 0;
  int   nerr = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchecks++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: decode to real, multiply exactly in double, round to single (RNE).
  function automatic real f2r(input logic [31:0] a);
    real v;
    int  e;
    v = 1.0 + real'(a[22:0]) / 8388608.0;
    e = int'(a[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return a[31] ? -v : v;
  endfunction

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [22:0] keep;
    logic [28:0] rem;
    logic [23:0] k24;
    int          fe;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      return {a[31] ^ b[31], 31'd0};
    d    = $realtobits(f2r(a) * f2r(b));
    fe   = int'(d[62:52]) - 1023 + 127;
    keep = d[51:29];
    rem  = d[28:0];
    k24  = {1'b0, keep};
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0]))
      k24 = k24 + 24'd1;
    if (k24[23])
      fe++;
    return {d[63], 8'(fe), k24[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  // mode 0 normal, 1 unit 2 forced to 0x40C00001, 2 unit 1 never finishes
  task automatic push_expect(input logic [31:0] a, input logic [31:0] b, input int mode);
    exp_t        e;
    logic [31:0] r;
    r = mul_ref(a, b);
    for (int k = 0; k < N; k++) begin
      e.is_done = 1'b0;
      e.idx     = 2'(k);
      e.data    = r;
      e.mm      = 1'b0;
      e.to      = 1'b0;
      if (mode == 1 && k == 2) e.data = 32'h40C00001;
      if (mode == 2 && k == 1) e.data = QNAN;
      sbq.push_back(e);
    end
    e.is_done = 1'b1;
    e.idx     = 2'd0;
    e.data    = 32'd0;
    e.mm      = (mode == 1);
    e.to      = (mode == 2);
    sbq.push_back(e);
  endtask

  // Monitor: every beat and every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (res_valid) begin
        chk("beat_expected", 32'(sbq.size() > 0 && !sbq[0].is_done), 32'd1);
        if (sbq.size() > 0 && !sbq[0].is_done) begin
          e = sbq.pop_front();
          chk("beat_idx", 32'(res_idx), 32'(e.idx));
          chk("beat_res", res, e.data);
        end
      end
      if (done) begin
        chk("done_expected", 32'(sbq.size() > 0 && sbq[0].is_done), 32'd1);
        chk("done_with_valid", 32'(res_valid), 32'd0);
        if (sbq.size() > 0 && sbq[0].is_done) begin
          e = sbq.pop_front();
          chk("mismatch", 32'(mismatch), 32'(e.mm));
          chk("timeout", 32'(timeout), 32'(e.to));
        end
      end
    end
  end

  task automatic wait_done(output int lat, input int acc);
    int n;
    for (n = 0; n < 300 && !done; n++) @(negedge clk);
    chk("done_seen", 32'(done), 32'd1);
    lat = cyc - acc;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode,
                        input bit chk_launch, input int exp_lat);
    int acc, lat;
    logic [N-1:0] oh;
    @(negedge clk);
    op1 = a; op2 = b; ready = 1'b1;
    push_expect(a, b, mode);
    @(negedge clk);
    ready = 1'b0; acc = cyc;
    op1 = rnd_op(); op2 = rnd_op();
    if (chk_launch) begin
      for (int c = 0; c <= (N - 1) * S; c++) begin
        if (c > 0) @(negedge clk);
        oh = '0;
        for (int k = 0; k < N; k++) if (c == k * S) oh[k] = 1'b1;
        chk("unit_ready", 32'(dut.unit_ready), 32'(oh));
        chk("busy_launch", 32'(busy), 32'd1);
      end
    end
    wait_done(lat, acc);
    if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_res", res, 32'd0);
    chk("rst_idx", 32'(res_idx), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_unit_ready", 32'(dut.unit_ready), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", nchecks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, last_done;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    run_op(32'h40000000, 32'h40400000, 0, 1'b1, MIN_LAT);
    run_op(32'hBF800000, 32'h3F000000, 0, 1'b1, MIN_LAT);
    run_op(32'h00000000, 32'hC0400000, 0, 1'b0, MIN_LAT);
    for (int i = 0; i < 20; i++)
      run_op(rnd_op(), rnd_op(), 0, 1'b0, MIN_LAT);

    force dut.g_unit[2].u_res = 32'h40C00001;
    run_op(32'h40000000, 32'h40400000, 1, 1'b0, MIN_LAT);
    release dut.g_unit[2].u_res;

    force dut.g_unit[1].u_done = 1'b0;
    run_op(32'h40000000, 32'h40400000, 2, 1'b0, (N - 1) * S + 1 + TO + N);
    release dut.g_unit[1].u_done;

    // Abort an operation stuck in WAIT.
    force dut.g_unit[1].u_done = 1'b0;
    @(negedge clk);
    op1 = 32'h40000000; op2 = 32'h40400000; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_in_wait", 32'(busy), 32'd1);
    chk("valid_in_wait", 32'(res_valid), 32'd0);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    release dut.g_unit[1].u_done;
    repeat (30) @(negedge clk);
    chk("busy_after_abort", 32'(busy), 32'd0);
    run_op(32'h40000000, 32'h40400000, 0, 1'b0, MIN_LAT);

    // Back-to-back with ready held and operands churning every cycle.
    ndone = 0; last_done = -1;
    for (int n = 0; n < 200 && ndone < 3; n++) begin
      @(negedge clk);
      if (done) begin
        if (last_done >= 0) chk("b2b_interval", 32'(cyc - last_done), 32'(MIN_LAT + 2));
        last_done = cyc;
        ndone++;
        if (ndone == 3) ready = 1'b0;
      end
      if (ndone < 3) begin
        op1 = rnd_op(); op2 = rnd_op();
        if (!busy) begin
          push_expect(op1, op2, 0);
          ready = 1'b1;
        end
      end
    end
    chk("b2b_done_count", 32'(ndone), 32'd3);

    repeat (15) @(negedge clk);
    chk("busy_end", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
